niosballe_nios2_gen2_0_cpu_div_cell: RTL and testbench
======================================================

// Module: niosballe_nios2_gen2_0_cpu_div_cell
// PURPOSE
//  Iterative restoring divider for the Nios II gen2 core: the inverse companion to the multiply cell.
//  Executes div/divu from E-stage operands and returns the quotient to the M/W stages.
//  Runs WIDTH iterations behind a start/busy/done handshake with constant latency.
//  Supports pipeline kill.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count.
// PORTS
//  clk         in   1      core clock
//  reset_n     in   1      asynchronous active-low reset
//  E_src1      in   WIDTH  dividend, sampled on accepted start
//  E_src2      in   WIDTH  divisor, sampled on accepted start
//  div_start   in   1      start request; accepted only when div_busy=0
//  div_signed  in   1      1=div (two's complement), 0=divu; sampled with start
//  div_kill    in   1      pipeline flush; aborts the operation in flight
//  div_busy    out  1      operation in flight (state != IDLE)
//  div_done    out  1      1-cycle pulse; results valid from this cycle on
//  div_quot    out  WIDTH  quotient, held until the next done
//  div_rem     out  WIDTH  remainder, held until the next done
// BEHAVIOUR
//  Reset: state=IDLE; div_busy=0, div_done=0, div_quot=0, div_rem=0; all internal registers 0.
//  FSM states:
//   - IDLE: start & !kill -> PREP; latch operands and div_signed.
//   - PREP (1 cycle): take magnitudes when signed; record q_neg=s1^s2, r_neg=s1; record divz=(E_src2==0); clear the partial remainder; cnt=WIDTH-1.
//   - ITER (WIDTH cycles): per cycle, rem={rem,dvd[MSB]} (WIDTH+1 bits); if rem>=dvs then subtract and shift in q bit 1, else shift in 0. cnt-- ; at cnt==0 go to FIX.
//   - FIX (1 cycle): negate quotient if q_neg, negate remainder if r_neg; register both into div_quot/div_rem; go to IDLE and set div_done=1 on the next cycle.
//  Latency:
//   - Constant: div_done is high exactly WIDTH+2 cycles after the edge that sampled div_start (34 for WIDTH=32). The divide-by-zero case uses the same latency.
//   - div_busy is high from the cycle after acceptance through FIX. During the div_done cycle div_busy=0.
//  Divide by zero: FIX overrides the results: quot=all ones, rem=dividend as given (unsigned and signed alike).
//  Signed overflow (-2^(WIDTH-1) / -1): quot=0x80000000, rem=0 (wraps naturally; no special case).
//  Division truncates toward zero; the remainder takes the dividend's sign.
//  Simultaneous events:
//   - div_start while busy: ignored, no queueing.
//   - div_start in the div_done cycle: accepted.
//   - div_kill in any state: state -> IDLE next edge, no div_done; div_quot/div_rem keep their previous values.
//   - div_kill with div_start in the same cycle: kill wins; the start is dropped.
//  Reset mid-operation: immediate return to reset values; no div_done.
// STRUCTURE
//  Package niosballe_div_pkg:
//   - FSM state encoding (IDLE, PREP, ITER, FIX).
//   - DIV_WIDTH_DEFAULT=32.
//   - Counter width = $clog2(WIDTH).
//  Sub-module niosballe_div_step: combinational single restoring iteration (rem_in, dvd_msb, dvs -> rem_out, q_bit).
//  Top level holds the FSM, counter, operand/remainder shift registers, sign fix-up and output registers.
// TESTING
//  Unsigned: divu 100/7 -> quot=14, rem=2; div_done exactly 34 cycles after start; busy low during done.
//  Signed: div -7/2 -> quot=0xFFFFFFFD, rem=0xFFFFFFFF. Also 7/-2 -> quot=0xFFFFFFFD, rem=1.
//  Corner cases:
//   - 5/0 in both modes -> quot=0xFFFFFFFF, rem=5, latency 34.
//   - Signed 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0.
//  Kill: assert div_kill 10 cycles into ITER -> no done pulse, busy=0 next cycle, outputs unchanged. A new divu 0xFFFFFFFF/3 -> 0x55555555 r0.
//  Handshake: start while busy is ignored (outputs match the first op only). A start in the done cycle of 9/3 launches 20/6 -> 3 r2 after 34 more cycles.
//  Reset: pulse reset_n low mid-ITER -> all outputs 0 asynchronously; no done; the next op completes correctly.

Source files
------------

// File: rtl/niosballe_div_pkg.sv
// Shared types and constants for the Nios II gen2 iterative divide cell.
package niosballe_div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;
  localparam int DIV_CNT_W_DEFAULT = $clog2(DIV_WIDTH_DEFAULT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_ITER = 2'd2,
    ST_FIX  = 2'd3
  } div_state_e;

  function automatic int div_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/niosballe_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module niosballe_div_step
  import niosballe_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;

  // rem_i < dvs_i holds, so the difference fits in WIDTH+1 bits and its MSB is the borrow.
  always_comb begin
    rem_shift = {rem_i, dvd_msb_i};
    diff      = rem_shift - {1'b0, dvs_i};
    q_bit_o   = ~diff[WIDTH];
    rem_o     = q_bit_o ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  end

endmodule

// File: rtl/niosballe_nios2_gen2_0_cpu_div_cell.sv
// Iterative restoring divider (div/divu) with start/busy/done handshake,
// constant WIDTH+2 cycle latency and pipeline kill.
//   state | meaning
//   IDLE  | waiting for start; operands latched on acceptance
//   PREP  | magnitudes, sign flags, divide-by-zero flag, counter load
//   ITER  | one quotient bit per cycle, WIDTH cycles
//   FIX   | sign fix-up / div-by-zero override, results registered
module niosballe_nios2_gen2_0_cpu_div_cell
  import niosballe_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] E_src1,
  input  logic [WIDTH-1:0] E_src2,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic             div_kill,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem
);

  localparam int CNT_W = div_cnt_w(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d, remo_q, remo_d;
  logic             sgn_q, sgn_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic             divz_q, divz_d, done_q, done_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  niosballe_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    divz_d  = divz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    done_d  = 1'b0;
    // Kill beats everything, including a same-cycle start.
    if (div_kill) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (div_start) begin
            state_d = ST_PREP;
            a_d     = E_src1;
            b_d     = E_src2;
            sgn_d   = div_signed;
          end
        end
        ST_PREP: begin
          dvd_d   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
          dvs_d   = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
          q_neg_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          r_neg_d = sgn_q & a_q[WIDTH-1];
          divz_d  = (b_q == '0);
          rem_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = ST_ITER;
        end
        ST_ITER: begin
          rem_d = step_rem;
          dvd_d = {dvd_q[WIDTH-2:0], step_q};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = ST_FIX;
        end
        ST_FIX: begin
          if (divz_q) begin
            quot_d = '1;
            remo_d = a_q;
          end else begin
            quot_d = q_neg_q ? -dvd_q : dvd_q;
            remo_d = r_neg_q ? -rem_q : rem_q;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      divz_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      divz_q  <= divz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      done_q  <= done_d;
    end
  end

  assign div_busy = (state_q != ST_IDLE);
  assign div_done = done_q;
  assign div_quot = quot_q;
  assign div_rem  = remo_q;

endmodule

// File: tb/tb_niosballe_nios2_gen2_0_cpu_div_cell.sv
// Scoreboard bench for the divide cell: the driver pushes expected results
// from a plain-arithmetic model, a monitor pops and checks on each done pulse.
module tb_niosballe_nios2_gen2_0_cpu_div_cell;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           launch;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] E_src1 = '0, E_src2 = '0;
  logic         div_start = 1'b0, div_signed = 1'b0, div_kill = 1'b0;
  logic         div_busy, div_done;
  logic [W-1:0] div_quot, div_rem;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0, passes = 0, done_cnt = 0;

  niosballe_nios2_gen2_0_cpu_div_cell #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .E_src1     (E_src1),
    .E_src2     (E_src2),
    .div_start  (div_start),
    .div_signed (div_signed),
    .div_kill   (div_kill),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Truncating division done in 64-bit arithmetic so the overflow case wraps cleanly.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t   e;
    longint sa, sd;
    e.launch = 0;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else if (s) begin
      sa  = longint'($signed(a));
      sd  = longint'($signed(b));
      e.q = W'(sa / sd);
      e.r = W'(sa % sd);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n && div_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quot", div_quot, e.q);
        check("rem", div_rem, e.r);
        check("latency", W'(cyc - e.launch), W'(LAT));
        check("busy_in_done", {31'd0, div_busy}, 32'd0);
      end
    end
  end

  // Drives start in the current cycle; caller is at a negedge with the cell idle.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit track);
    exp_t e;
    E_src1 = a; E_src2 = b; div_signed = s; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    if (track) begin
      e = model(a, b, s);
      e.launch = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit track);
    @(negedge clk);
    drive_start(a, b, s, track);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", W'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] sq, sr, a, b;
    logic         s;
    int           n, d0;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, div_busy}, 32'd0);
    check("rst_done", {31'd0, div_done}, 32'd0);
    check("rst_quot", div_quot, 32'd0);
    check("rst_rem", div_rem, 32'd0);
    reset_n = 1'b1;

    // Directed cases.
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    @(negedge clk);
    check("busy_after_accept", {31'd0, div_busy}, 32'd1);
    wait_empty();
    issue(-32'sd7, 32'd2, 1'b1, 1'b1);            wait_empty();
    issue(32'd7, -32'sd2, 1'b1, 1'b1);            wait_empty();
    issue(32'd5, 32'd0, 1'b0, 1'b1);              wait_empty();
    issue(32'd5, 32'd0, 1'b1, 1'b1);              wait_empty();
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1); wait_empty();
    issue(-32'sd5, 32'd0, 1'b1, 1'b1);            wait_empty();

    // Kill 10 cycles into ITER: no done, outputs held.
    sq = div_quot; sr = div_rem; d0 = done_cnt;
    issue(32'd12345, 32'd17, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    div_kill = 1'b1;
    @(posedge clk); #1;
    div_kill = 1'b0;
    check("kill_busy", {31'd0, div_busy}, 32'd0);
    repeat (LAT + 4) @(negedge clk);
    check("kill_no_done", W'(done_cnt - d0), 32'd0);
    check("kill_quot_held", div_quot, sq);
    check("kill_rem_held", div_rem, sr);
    issue(32'hFFFF_FFFF, 32'd3, 1'b0, 1'b1);      wait_empty();

    // Kill together with start: start dropped.
    d0 = done_cnt;
    @(negedge clk);
    div_kill = 1'b1;
    drive_start(32'd50, 32'd5, 1'b0, 1'b0);
    div_kill = 1'b0;
    check("kill_start_busy", {31'd0, div_busy}, 32'd0);
    repeat (LAT + 4) @(negedge clk);
    check("kill_start_no_done", W'(done_cnt - d0), 32'd0);

    // Start while busy is ignored.
    d0 = done_cnt;
    issue(32'd1000, 32'd9, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    drive_start(32'd1, 32'd1, 1'b0, 1'b0);
    wait_empty();
    repeat (LAT + 4) @(negedge clk);
    check("busy_start_done_cnt", W'(done_cnt - d0), 32'd1);

    // Start in the done cycle is accepted.
    issue(32'd9, 32'd3, 1'b0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!div_done && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    check("done_seen_9_3", {31'd0, div_done}, 32'd1);
    drive_start(32'd20, 32'd6, 1'b0, 1'b1);
    wait_empty();

    // Asynchronous reset mid-ITER.
    d0 = done_cnt;
    issue(32'd777, 32'd5, 1'b1, 1'b0);
    repeat (15) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, div_busy}, 32'd0);
    check("arst_done", {31'd0, div_done}, 32'd0);
    check("arst_quot", div_quot, 32'd0);
    check("arst_rem", div_rem, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    check("arst_no_done", W'(done_cnt - d0), 32'd0);
    issue(32'd1000, -32'sd7, 1'b1, 1'b1);         wait_empty();

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = -W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = W'($urandom_range(0, 300));
        default: a = W'($urandom);
      endcase
      if (i % 10 == 9) b = 32'hFFFF_FFFF;
      issue(a, b, s, 1'b1);
      wait_empty();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
